ym3438_ch_freq_regs: RTL
========================

Name: ym3438_ch_freq_regs

Overview:
- Register-side producer for the LFO/phase path. It captures CPU writes to the frequency and LFO registers and drives the time-multiplexed per-slot fnum, block, pms, ams and pan, plus the LFO control registers 0x21/0x22.
- Sits between the bus write decoder and the LFO/phase-generator blocks.
- Its values are sequenced by a 24-slot counter locked to fsm_sel23.

Parameters:
- SYNC_SLOT, 23: slot index during which fsm_sel23 is asserted; the counter wraps to 0 after it.
- RESET_PAN, 2'b11: reset value of {L,R} in every B4-B6 register.

Ports:
- MCLK  in  1  sole clock, rising edge.
- IC  in  1  asynchronous active-low reset.
- c1  in  1  slot-advance strobe, one MCLK cycle per slot.
- fsm_sel23  in  1  high during slot SYNC_SLOT.
- wr_en  in  1  single-cycle register write strobe.
- wr_addr  in  9  bit8 = part (0: ch1-3, 1: ch4-6), [7:0] = register address.
- wr_data  in  8  write data.
- fnum  out  11  F-number for the current slot.
- block  out  3  block for the current slot.
- pms  out  3  phase-mod sensitivity.
- ams  out  2  amplitude-mod sensitivity.
- pan_l  out  1  left enable.
- pan_r  out  1  right enable.
- lfo  out  4  reg 0x22 [3:0].
- reg_21  out  8  test register 0x21.
- slot  out  5  current slot index, 0..23.

Behaviour:
- Reset (IC low, async):
  - slot=0.
  - All fnum/block/ams/pms registers and both hi latches = 0.
  - Pan registers = RESET_PAN.
  - lfo=0, reg_21=0, 0x27 shadow=0.
  - All outputs reflect slot 0 with those values: pan_l=pan_r=1, rest 0.
- Slot counter:
  - On MCLK edge with c1=1: if fsm_sel23=1, next slot=0; else slot+1.
  - At slot=23 without fsm_sel23, wrap to 0.
  - fsm_sel23 asserted at another slot forces resync to 0.
  - c1=0 holds the counter.
- Slot mapping:
  - channel = slot mod 6 (0-2 part0, 3-5 part1).
  - operator group = slot/6, mapped to op order 1,3,2,4.
- Outputs:
  - Registered; loaded on the same edge the counter advances, with values for the new slot.
  - Latency from c1 edge to valid outputs: 0 cycles after the edge.
  - Channel fields are read from register state before any same-edge write commits.
- Write decode (wr_en=1; ch = wr_addr[1:0], invalid when 3; part from wr_addr[8]):
  - A4-A6: hi latch <= wr_data[5:0]; channel state unchanged.
  - A0-A2: fnum[7:0] <= wr_data, {block, fnum[10:8]} <= hi latch, committed atomically in one edge.
  - B4-B6: {L,R} <= wr_data[7:6], ams <= wr_data[5:4], pms <= wr_data[2:0].
  - 0x22 (part0 only): lfo <= wr_data[3:0].
  - 0x21 (part0 only): reg_21 <= wr_data.
  - 0x27: shadow[7:6] <= wr_data[7:6].
  - Any other address, part1 with 0x21/0x22, or ch=3: ignored.
- The hi latch persists after commit; repeated A0 writes reuse it.
- Write during reset: ignored.
- Write on the same edge as c1: takes effect in storage; visible at the next slot visit of that channel, i.e. 6 slots later at the earliest.

Optional Feature:
- Macro YM_CH3_SPECIAL_EN.
- Defined:
  - Adds 3 per-operator fnum/block registers for channel index 2 (part0 only).
  - AC-AE load a second hi latch; A8-AA commit from it.
  - When shadow[7:6] != 0, ch3 slots use: op1 <- A9/AD, op2 <- AA/AE, op3 <- A8/AC, op4 <- main A2/A6.
  - When shadow[7:6] == 0, all ch3 slots use A2/A6.
- Undefined:
  - A8-AE are ignored.
  - The 0x27 shadow has no effect on outputs.

Test Plan:
- Reset then c1 pulses → slot 0,1..23,0 sequence; pan_l=pan_r=1; fnum=0 for every slot.
- Write A4=0x2C then A0=0x55, part0 → ch1 slots (0,6,12,18) show block=5, fnum=0x455; hi latch reused: A1=0x11 → ch2 fnum=0x411, block=5.
- Write A4=0x3F with no A0 → ch1 fnum/block unchanged for a full 24-slot cycle.
- Write part1 B6=0x57 → ch6 slots: pan_l=0, pan_r=1, ams=1, pms=7; write part1 0x22 → lfo unchanged.
- fsm_sel23 asserted at slot 10 with c1 → next slot=0; IC pulsed low mid-cycle → immediate slot=0 and registers cleared.
- YM_CH3_SPECIAL_EN: write 0x27=0x40, AD=0x12, A9=0x34 → ch3 op1 slot (slot 2): block=2, fnum=0x234; 0x27=0x00 → slot 2 reverts to A2/A6 value.

Source files
------------

// File: rtl/ym3438_ch_freq_regs.sv
// Channel frequency/pan register file with per-slot readout for the LFO/phase path.
// Latency: slot outputs are registered and valid right after the c1 edge that advances the slot.
// Backpressure: none; writes always commit in one MCLK cycle, c1=0 freezes slot and outputs.
//
// Ports: MCLK/IC clock and async active-low reset; c1 slot strobe; fsm_sel23 slot resync;
//        wr_en/wr_addr/wr_data register write (wr_addr[8] selects part);
//        fnum/block/pms/ams/pan_l/pan_r per-slot values; lfo/reg_21 global regs; slot index.
// Build option: define YM_CH3_SPECIAL_EN for per-operator fnum/block on channel 3 (0x27 mode).
module ym3438_ch_freq_regs #(
  parameter int unsigned SYNC_SLOT = 23,
  parameter logic [1:0]  RESET_PAN = 2'b11
) (
  input  logic        MCLK,
  input  logic        IC,
  input  logic        c1,
  input  logic        fsm_sel23,
  input  logic        wr_en,
  input  logic [8:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic [10:0] fnum,
  output logic [2:0]  block,
  output logic [2:0]  pms,
  output logic [1:0]  ams,
  output logic        pan_l,
  output logic        pan_r,
  output logic [3:0]  lfo,
  output logic [7:0]  reg_21,
  output logic [4:0]  slot
);

  // Per-channel state, index 0..2 = part0 ch1-3, 3..5 = part1 ch4-6.
  logic [10:0] fnum_r  [6];
  logic [2:0]  block_r [6];
  logic [2:0]  pms_r   [6];
  logic [1:0]  ams_r   [6];
  logic [1:0]  pan_r_q [6];   // {L,R}
  logic [5:0]  hi_latch [2];  // one A4-A6 latch per part: {block, fnum[10:8]}

`ifdef YM_CH3_SPECIAL_EN
  logic [10:0] sp_fnum  [3];  // index 0..2 = A8/A9/AA
  logic [2:0]  sp_block [3];
  logic [5:0]  sp_latch;
  logic [1:0]  shadow;        // 0x27 [7:6]
`endif

  // Write decode
  logic       part;
  logic [1:0] ach;
  logic [5:0] agrp;
  logic       ch_ok;
  logic [2:0] wch;
  logic       hit_a0, hit_a4, hit_b4, hit_21, hit_22;

  assign part   = wr_addr[8];
  assign ach    = wr_addr[1:0];
  assign agrp   = wr_addr[7:2];
  assign ch_ok  = (ach != 2'd3);
  assign wch    = part ? (3'd3 + {1'b0, ach}) : {1'b0, ach};
  assign hit_a0 = wr_en && ch_ok && (agrp == 6'h28);
  assign hit_a4 = wr_en && ch_ok && (agrp == 6'h29);
  assign hit_b4 = wr_en && ch_ok && (agrp == 6'h2D);
  assign hit_21 = wr_en && (wr_addr == 9'h021);
  assign hit_22 = wr_en && (wr_addr == 9'h022);

`ifdef YM_CH3_SPECIAL_EN
  logic hit_a8, hit_ac, hit_27;
  assign hit_a8 = wr_en && ch_ok && !part && (agrp == 6'h2A);
  assign hit_ac = wr_en && ch_ok && !part && (agrp == 6'h2B);
  assign hit_27 = wr_en && (wr_addr[7:0] == 8'h27);
`endif

  // Register storage
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      for (int i = 0; i < 6; i++) begin
        fnum_r[i]  <= '0;
        block_r[i] <= '0;
        pms_r[i]   <= '0;
        ams_r[i]   <= '0;
        pan_r_q[i] <= RESET_PAN;
      end
      hi_latch[0] <= '0;
      hi_latch[1] <= '0;
      lfo         <= '0;
      reg_21      <= '0;
`ifdef YM_CH3_SPECIAL_EN
      for (int i = 0; i < 3; i++) begin
        sp_fnum[i]  <= '0;
        sp_block[i] <= '0;
      end
      sp_latch <= '0;
      shadow   <= '0;
`endif
    end else begin
      if (hit_a4) hi_latch[part] <= wr_data[5:0];
      // The latch is not cleared on commit, so back-to-back A0 writes share one A4 value.
      if (hit_a0) begin
        fnum_r[wch]  <= {hi_latch[part][2:0], wr_data};
        block_r[wch] <= hi_latch[part][5:3];
      end
      if (hit_b4) begin
        pan_r_q[wch] <= wr_data[7:6];
        ams_r[wch]   <= wr_data[5:4];
        pms_r[wch]   <= wr_data[2:0];
      end
      if (hit_22) lfo    <= wr_data[3:0];
      if (hit_21) reg_21 <= wr_data;
`ifdef YM_CH3_SPECIAL_EN
      if (hit_ac) sp_latch <= wr_data[5:0];
      if (hit_a8) begin
        sp_fnum[ach]  <= {sp_latch[2:0], wr_data};
        sp_block[ach] <= sp_latch[5:3];
      end
      if (hit_27) shadow <= wr_data[7:6];
`endif
    end
  end

  // Next slot and the values it selects; storage is read before this edge's write lands.
  logic [4:0]  nslot;
  logic [2:0]  nch;
  logic [10:0] sel_fnum;
  logic [2:0]  sel_block;

`ifdef YM_CH3_SPECIAL_EN
  logic [1:0] ngrp;
  logic [1:0] sp_idx;
`endif

  always_comb begin
    nslot = slot + 5'd1;
    if (fsm_sel23 || (slot == 5'(SYNC_SLOT))) nslot = '0;
    nch       = 3'(nslot % 5'd6);
    sel_fnum  = fnum_r[nch];
    sel_block = block_r[nch];
`ifdef YM_CH3_SPECIAL_EN
    ngrp = 2'(nslot / 5'd6);
    // Slot groups run op1,op3,op2,op4; op1->A9, op3->A8, op2->AA, op4 keeps the main A2.
    case (ngrp)
      2'd0:    sp_idx = 2'd1;
      2'd1:    sp_idx = 2'd0;
      default: sp_idx = 2'd2;
    endcase
    if ((nch == 3'd2) && (shadow != 2'b00) && (ngrp != 2'd3)) begin
      sel_fnum  = sp_fnum[sp_idx];
      sel_block = sp_block[sp_idx];
    end
`endif
  end

  // Slot counter and registered per-slot outputs
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      slot  <= '0;
      fnum  <= '0;
      block <= '0;
      pms   <= '0;
      ams   <= '0;
      pan_l <= RESET_PAN[1];
      pan_r <= RESET_PAN[0];
    end else if (c1) begin
      slot  <= nslot;
      fnum  <= sel_fnum;
      block <= sel_block;
      pms   <= pms_r[nch];
      ams   <= ams_r[nch];
      pan_l <= pan_r_q[nch][1];
      pan_r <= pan_r_q[nch][0];
    end
  end

endmodule
